// File: rtl/dac_pkg.sv
// Shared types and constants for the codec DAC transmit path.
package dac_pkg;

   localparam int unsigned SAMPLE_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      SHIFT_R = 2'd2
   } state_t;

   // Bit-index width able to hold the value n (one past the last bit of a word).
   function automatic int unsigned bidx_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/dac_send_if.sv
// Sample handshake between upstream audio logic and the DAC serialiser.
interface dac_send_if #(
   parameter int unsigned N = 16
) ();
   logic         sample_valid;
   logic [N-1:0] sample_data;
   logic         sample_ready;

   modport master (output sample_valid, output sample_data, input sample_ready);
   modport slave  (input sample_valid, input sample_data, output sample_ready);
endinterface

// File: rtl/lrc_edge_detect.sv
// Registers the codec LR clock and flags its rising edge; shared with the ADC side.
module lrc_edge_detect (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_lrc,
   output logic o_redge_c
);

   logic r_lrc_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) r_lrc_q <= 1'b0;
      else         r_lrc_q <= i_lrc;
   end

   assign o_redge_c = ~r_lrc_q & i_lrc;

endmodule

// File: rtl/dac_send.sv
// Serialises buffered PCM words onto DACDAT, MSB first, framed by DACLRC rising edges.
// DAC_SEND_STEREO_DUP_EN: repeat each word in the right slot (2N bits per frame).
module dac_send
   import dac_pkg::*;
#(
   parameter int unsigned N      = SAMPLE_W,
   parameter int unsigned UCNT_W = 8
) (
   input  logic              bclk,
   input  logic              reset,
   input  logic              daclrc,
   dac_send_if.slave         s_if,
   output logic              dacdat,
   output logic              underrun,
   output logic [UCNT_W-1:0] underrun_count
);

   localparam int unsigned BI_W = bidx_w(N);

   state_t            r_state,    w_state_n;
   logic [BI_W-1:0]   r_bit_idx,  w_bit_idx_n;
   logic [N-1:0]      r_shift,    w_shift_n;
   logic [N-1:0]      r_buf,      w_buf_n;
   logic              r_buf_full, w_buf_full_n;
   logic              r_dacdat,   w_dacdat_n;
   logic              r_underrun, w_underrun_n;
   logic [UCNT_W-1:0] r_ucnt,     w_ucnt_n;
`ifdef DAC_SEND_STEREO_DUP_EN
   logic [N-1:0]      r_word,     w_word_n;
`endif

   logic w_redge;
   logic w_xfer;

   lrc_edge_detect u_lrc_edge (
      .i_clk     (bclk),
      .i_reset   (reset),
      .i_lrc     (daclrc),
      .o_redge_c (w_redge)
   );

   assign s_if.sample_ready = ~r_buf_full & ~reset;
   assign w_xfer            = s_if.sample_valid & s_if.sample_ready;

   // Next-state: buffer fill, frame start (with underrun accounting), bit shifting
   always_comb begin
      w_state_n    = r_state;
      w_bit_idx_n  = r_bit_idx;
      w_shift_n    = r_shift;
      w_buf_n      = r_buf;
      w_buf_full_n = r_buf_full;
      w_dacdat_n   = 1'b0;
      w_underrun_n = r_underrun;
      w_ucnt_n     = r_ucnt;
`ifdef DAC_SEND_STEREO_DUP_EN
      w_word_n     = r_word;
`endif

      if (w_xfer) begin
         w_buf_n      = s_if.sample_data;
         w_buf_full_n = 1'b1;
      end

      if (w_redge) begin
         if (r_buf_full) begin
            w_shift_n    = r_buf;
            w_buf_full_n = 1'b0;
         end else begin
            w_shift_n    = '0;
            w_underrun_n = 1'b1;
            if (r_ucnt != {UCNT_W{1'b1}}) w_ucnt_n = r_ucnt + UCNT_W'(1);
         end
`ifdef DAC_SEND_STEREO_DUP_EN
         w_word_n    = w_shift_n;
`endif
         w_dacdat_n  = w_shift_n[N-1];
         w_bit_idx_n = BI_W'(1);
         w_state_n   = SHIFT;
      end else begin
         case (r_state)
            SHIFT: begin
               if (r_bit_idx == BI_W'(N)) begin
`ifdef DAC_SEND_STEREO_DUP_EN
                  // Left slot done: replay the same word in the right slot
                  w_shift_n   = r_word;
                  w_dacdat_n  = r_word[N-1];
                  w_bit_idx_n = BI_W'(1);
                  w_state_n   = SHIFT_R;
`else
                  w_state_n   = IDLE;
`endif
               end else begin
                  w_dacdat_n  = r_shift[N-2];
                  w_shift_n   = r_shift << 1;
                  w_bit_idx_n = r_bit_idx + BI_W'(1);
               end
            end
`ifdef DAC_SEND_STEREO_DUP_EN
            SHIFT_R: begin
               if (r_bit_idx == BI_W'(N)) begin
                  w_state_n   = IDLE;
               end else begin
                  w_dacdat_n  = r_shift[N-2];
                  w_shift_n   = r_shift << 1;
                  w_bit_idx_n = r_bit_idx + BI_W'(1);
               end
            end
`endif
            default: w_state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge bclk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_buf      <= '0;
         r_buf_full <= 1'b0;
         r_dacdat   <= 1'b0;
         r_underrun <= 1'b0;
         r_ucnt     <= '0;
`ifdef DAC_SEND_STEREO_DUP_EN
         r_word     <= '0;
`endif
      end else begin
         r_state    <= w_state_n;
         r_bit_idx  <= w_bit_idx_n;
         r_shift    <= w_shift_n;
         r_buf      <= w_buf_n;
         r_buf_full <= w_buf_full_n;
         r_dacdat   <= w_dacdat_n;
         r_underrun <= w_underrun_n;
         r_ucnt     <= w_ucnt_n;
`ifdef DAC_SEND_STEREO_DUP_EN
         r_word     <= w_word_n;
`endif
      end
   end

   assign dacdat         = r_dacdat;
   assign underrun       = r_underrun;
   assign underrun_count = r_ucnt;

endmodule

// File: doc/dac_send.md
Name: dac_send

Overview:
- Transmit counterpart of the microphone capture path: serialises N-bit signed PCM words onto the codec's DACDAT line in the same DSP-style framing used on the ADC side.
- Clocked directly by the codec BCLK.
- Frame start is marked by a DACLRC rising edge; MSB first.
- Upstream logic (tone generator / pitch-shift output) hands samples in over a valid/ready handshake into a one-entry holding buffer.

Parameters:
- N, 16, sample word width in bits (N >= 2, N <= 32)
- UCNT_W, 8, width of saturating underrun counter

Ports:
- bclk  input  1  codec bit clock; all logic on posedge bclk
- reset  input  1  synchronous, active-high reset
- daclrc  input  1  codec DAC frame clock; rising edge starts a frame
- sample_valid  input  1  upstream word available
- sample_data  input  N  upstream word, two's complement
- sample_ready  output  1  holding buffer can accept a word
- dacdat  output  1  serial data to codec
- underrun  output  1  sticky: a frame started with no buffered word
- underrun_count  output  UCNT_W  saturating count of underrun frames

Behaviour:
- Clock and reset: one clock (bclk). Reset is synchronous and active-high.
- Reset values:
  - dacdat=0, sample_ready=0 while reset is high, underrun=0, underrun_count=0
  - buffer empty, state IDLE, daclrc_q=0
- Edge detect: daclrc_q registers daclrc each posedge; redge = ~daclrc_q & daclrc.
- Handshake:
  - sample_ready = ~buf_full & ~reset, combinational from registered state.
  - A transfer occurs on a posedge with sample_valid & sample_ready; the buffer captures sample_data and becomes full.
  - sample_data must be held stable only in the transfer cycle.
- State machine: IDLE, SHIFT.
  - Frame start: on a posedge with redge (any state):
    - If buf_full: shift register loads the buffer word; buf_full clears in the same cycle.
    - If buffer empty: shift register loads all zeros; underrun <= 1; underrun_count increments, saturating at all-ones.
    - dacdat <= bit N-1 of the loaded word in this same cycle.
    - bit_idx <= 1; state <= SHIFT.
  - SHIFT, no redge, bit_idx < N: dacdat <= word[N-1-bit_idx]; bit_idx increments.
  - SHIFT, bit_idx == N: dacdat <= 0; state <= IDLE.
  - IDLE: dacdat held 0.
- Latency:
  - MSB appears on dacdat immediately after the redge posedge; the codec samples it on the following BCLK rise.
  - The LSB is driven N-1 cycles after the MSB.
- Boundary conditions:
  - redge while in SHIFT (frame shorter than N bits): current word is abandoned and a new frame starts per the frame-start rules. No other error reporting.
  - redge and an input transfer in the same cycle with the buffer empty: the frame uses zeros (underrun) and the new word lands in the buffer for the next frame. No bypass.
  - redge with buffer full in the same cycle as sample_valid: sample_ready was 0, so no transfer; the buffer is free from the next cycle.
  - Reset mid-frame: everything returns to reset values on that posedge; the partial word is discarded; buffered data is lost.
  - bit_idx is $clog2(N+1) bits wide.

Optional Feature:
- Macro: DAC_SEND_STEREO_DUP_EN.
- Defined:
  - After the N left bits, the same word is shifted again as the right channel (bits N..2N-1), MSB first, via state SHIFT_R.
  - dacdat returns to 0 after 2N bits.
  - A redge during SHIFT_R restarts the frame as above.
- Undefined: only N bits are sent per frame; the right slot is 0.

Decomposition:
- Shared package dac_pkg: state enum (IDLE, SHIFT, SHIFT_R), default width constant SAMPLE_W=16, and helper constant for the bit-index width.
- One natural sub-module: lrc_edge_detect (registered daclrc plus rising-edge pulse). Reuse it on the ADC side later.

Test Plan:
- Reset, then push 16'hA5C3 before a daclrc rise → dacdat serial 1010_0101_1100_0011 on the 16 posedges starting at the redge cycle, then 0. sample_ready high again from the cycle after redge.
- No sample pushed, daclrc rise → 16 zero bits; underrun=1; underrun_count=1.
- 300 consecutive underrun frames → underrun_count saturates at 8'hFF.
- Push 16'h8001, then hold sample_valid with 16'h7FFE → second word accepted only after the next redge; frames carry 8001 then 7FFE.
- daclrc rises again after 10 bits of 16'hFFFF with 16'h0000 buffered → dacdat switches to 0000 frame at that edge; no residual 1s.
- Assert reset at bit 5 of a frame → dacdat=0, sample_ready=0 during reset; buffer empty afterwards. With DAC_SEND_STEREO_DUP_EN defined, 16'h1234 appears twice back-to-back (32 bits).
